// File: rtl/conv_image_feeder_if.sv
// Interface between conv_image_feeder and its host/downstream side.
// Slave modport is the feeder; master modport drives loads and ready.
`timescale 1ns/1ps
interface conv_image_feeder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_wen;
  logic [DATA_WIDTH-1:0] i_wdata0;
  logic [DATA_WIDTH-1:0] i_wdata1;
  logic [DATA_WIDTH-1:0] i_wdata2;
  logic                  o_full;
  logic                  i_ready;
  logic                  o_image_start;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_image0;
  logic [DATA_WIDTH-1:0] o_image1;
  logic [DATA_WIDTH-1:0] o_image2;
  logic                  o_last;
  logic                  o_done;

  modport slave (
    input  i_wen, i_wdata0, i_wdata1, i_wdata2, i_ready,
    output o_full, o_image_start, o_valid, o_image0, o_image1, o_image2,
           o_last, o_done
  );

  modport master (
    output i_wen, i_wdata0, i_wdata1, i_wdata2, i_ready,
    input  o_full, o_image_start, o_valid, o_image0, o_image1, o_image2,
           o_last, o_done
  );
endinterface

// File: rtl/conv_image_feeder.sv
// Frame buffer that loads one H x W 3-channel frame and streams it with valid/ready.
// Define IMAGE_FEEDER_PAD_EN to stream a generated 1-pixel zero border around the frame.
`timescale 1ns/1ps
module conv_image_feeder #(
  parameter int unsigned H          = 48,
  parameter int unsigned W          = 48,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  conv_image_feeder_if.slave  bus
);

  localparam int unsigned NPIX = H * W;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned PW   = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {LOAD, START, STREAM, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic            start_q, start_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [PW-1:0]   mem [NPIX];

  logic            mem_we_c;
  logic            adv_c;
  logic [AW-1:0]   rd_addr_c;
  logic [AW-1:0]   nxt_ptr_c;
  logic            nxt_inside_c;
  logic            nxt_last_c;

`ifdef IMAGE_FEEDER_PAD_EN
  localparam int unsigned SH = H + 2;
  localparam int unsigned SW = W + 2;
  localparam int unsigned RW = $clog2(SH);
  localparam int unsigned CW = $clog2(SW);

  logic [RW-1:0] row_q, row_d, nxt_row_c;
  logic [CW-1:0] col_q, col_d, nxt_col_c;

  // Raster position of the next streamed pixel; rd_ptr_q is the next interior buffer address
  always_comb begin
    nxt_row_c = '0;
    nxt_col_c = '0;
    if (state_q == STREAM) begin
      if (col_q == CW'(SW - 1)) begin
        nxt_row_c = row_q + RW'(1);
        nxt_col_c = '0;
      end else begin
        nxt_row_c = row_q;
        nxt_col_c = col_q + CW'(1);
      end
    end
    nxt_inside_c = (nxt_row_c != '0) && (nxt_row_c <= RW'(H)) &&
                   (nxt_col_c != '0) && (nxt_col_c <= CW'(W));
    nxt_last_c   = (nxt_row_c == RW'(SH - 1)) && (nxt_col_c == CW'(SW - 1));
    rd_addr_c    = (state_q == STREAM) ? rd_ptr_q : '0;
    nxt_ptr_c    = nxt_inside_c ? rd_addr_c + AW'(1) : rd_addr_c;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (adv_c) begin
      row_d = nxt_row_c;
      col_d = nxt_col_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
`else
  // rd_ptr_q is the buffer address of the pixel currently on the outputs
  always_comb begin
    rd_addr_c    = (state_q == STREAM) ? rd_ptr_q + AW'(1) : '0;
    nxt_inside_c = 1'b1;
    nxt_last_c   = (rd_addr_c == AW'(NPIX - 1));
    nxt_ptr_c    = rd_addr_c;
  end
`endif

  // Next-state and registered-output logic; adv_c loads the next pixel (prefetch)
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    start_d  = 1'b0;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    pix_d    = pix_q;
    mem_we_c = 1'b0;
    adv_c    = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.i_wen && !full_q) begin
          mem_we_c = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(NPIX - 1)) begin
            wr_ptr_d = '0;
            full_d   = 1'b1;
            start_d  = 1'b1;
            state_d  = START;
          end
        end
      end
      START: begin
        adv_c   = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (bus.i_ready) begin
          if (last_q) begin
            state_d  = DONE;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
            full_d   = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
          end else begin
            adv_c = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
    if (adv_c) begin
      valid_d  = 1'b1;
      last_d   = nxt_last_c;
      rd_ptr_d = nxt_ptr_c;
      pix_d    = nxt_inside_c ? mem[rd_addr_c] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      pix_q    <= pix_d;
    end
  end

  // Frame storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_ptr_q] <= {bus.i_wdata2, bus.i_wdata1, bus.i_wdata0};
    end
  end

  assign bus.o_full        = full_q;
  assign bus.o_image_start = start_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_last        = last_q;
  assign bus.o_done        = done_q;
  assign bus.o_image0      = pix_q[DATA_WIDTH-1:0];
  assign bus.o_image1      = pix_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.o_image2      = pix_q[3*DATA_WIDTH-1:2*DATA_WIDTH];

endmodule
